// File: rtl/signal_emitter_pkg.sv
// Shared constants for the signal emitter: FSM encodings and PRBS-7 (x^7+x^6+1) parameters.
package tart_signal_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/signal_emitter_prbs7.sv
// Clock-enabled PRBS-7 generator; bit_o is the MSB of the register, reload restores the seed.
module signal_prbs7
  import tart_signal_pkg::*;
(
  input  logic clock_i,
  input  logic reset_ni,
  input  logic load_i,
  input  logic advance_i,
  output logic bit_o
);

  logic [6:0] r_lfsr;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_lfsr <= PRBS7_SEED;
    end else if (load_i) begin
      r_lfsr <= PRBS7_SEED;
    end else if (advance_i) begin
      r_lfsr <= prbs7_next(r_lfsr);
    end
  end

  assign bit_o = r_lfsr[6];

endmodule

// File: rtl/signal_emitter.sv
// Serial bit-stream source: RATIO ticks per bit, phase-aligned start, one-shot period slips.
// Define SIGNAL_EMITTER_PRBS_EN to replace the valid/ready source with an internal PRBS-7.
module signal_emitter
  import tart_signal_pkg::*;
#(
  parameter int unsigned RATIO = 12,
  parameter int unsigned RBITS = 4,
  parameter int          DELAY = 3
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic [RBITS-1:0] phase_i,
  input  logic             drift_i,
  input  logic             slower_i,
  input  logic             valid_i,
  input  logic             data_i,
  output logic             ready_o,
  output logic             signal_o,
  output logic             strobe_o,
  output logic             underrun_o,
  output logic             locked_o
);

  localparam logic [RBITS-1:0] P_NOM  = RBITS'(RATIO);
  localparam logic [RBITS-1:0] P_SLOW = RBITS'(RATIO + 1);
  localparam logic [RBITS-1:0] P_FAST = RBITS'(RATIO - 1);

  logic [1:0]       r_state;
  logic [RBITS-1:0] r_phase_cnt;
  logic [RBITS-1:0] r_tick;
  logic [RBITS-1:0] r_period;
  logic             r_started;
  logic             r_pend;
  logic             r_slow;
  logic             r_signal;
  logic             r_strobe;
  logic             r_underrun;

  logic             w_run;
  logic             w_boundary;
  logic             w_full;
  logic             w_bit;
  logic [RBITS-1:0] w_phase;
  logic             w_unused;

  assign w_run      = (r_state == ST_RUN);
  assign w_boundary = w_run && (!r_started || (r_tick == r_period - 1'b1));
  assign w_phase    = (phase_i >= P_NOM) ? P_FAST : phase_i;

`ifdef SIGNAL_EMITTER_PRBS_EN
  logic w_prbs_bit;

  signal_prbs7 u_prbs (
    .clock_i   (clock_i),
    .reset_ni  (reset_ni),
    .load_i    ((r_state == ST_IDLE) && enable_i),
    .advance_i (w_boundary),
    .bit_o     (w_prbs_bit)
  );

  assign w_full   = 1'b1;
  assign w_bit    = w_prbs_bit;
  assign ready_o  = 1'b0;
  assign w_unused = valid_i ^ data_i ^ (DELAY != 0);
`else
  logic r_full;
  logic r_held;
  logic w_accept;

  assign ready_o  = (r_state != ST_IDLE) && !r_full;
  assign w_accept = valid_i && ready_o;
  assign w_full   = r_full;
  assign w_bit    = r_held;
  assign w_unused = (DELAY != 0);

  // Accept only happens while empty, so load-on-boundary covers the empty-and-reload case.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_full <= 1'b0;
      r_held <= 1'b0;
    end else if (!enable_i) begin
      r_full <= 1'b0;
      r_held <= 1'b0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_held <= data_i;
    end else if (w_boundary) begin
      r_full <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= ST_IDLE;
      r_phase_cnt <= '0;
      r_tick      <= '0;
      r_period    <= P_NOM;
      r_started   <= 1'b0;
      r_pend      <= 1'b0;
      r_slow      <= 1'b0;
      r_signal    <= 1'b0;
      r_strobe    <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (!enable_i) begin
      r_state     <= ST_IDLE;
      r_phase_cnt <= '0;
      r_tick      <= '0;
      r_period    <= P_NOM;
      r_started   <= 1'b0;
      r_pend      <= 1'b0;
      r_slow      <= 1'b0;
      r_signal    <= 1'b0;
      r_strobe    <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_strobe   <= w_boundary;
      r_underrun <= w_boundary && !w_full;

      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_ALIGN;
          r_phase_cnt <= w_phase;
        end
        ST_ALIGN: begin
          if (r_phase_cnt == '0) r_state <= ST_RUN;
          else                   r_phase_cnt <= r_phase_cnt - 1'b1;
        end
        default: r_state <= r_state;
      endcase

      if (w_boundary) begin
        r_tick    <= '0;
        r_started <= 1'b1;
        r_period  <= r_pend ? (r_slow ? P_SLOW : P_FAST) : P_NOM;
        if (w_full) r_signal <= w_bit;
      end else if (w_run) begin
        r_tick <= r_tick + 1'b1;
      end

      // A request on a boundary is left pending for the bit after the one starting now.
      if (w_boundary) r_pend <= 1'b0;
      if (drift_i && !r_pend) begin
        r_pend <= 1'b1;
        r_slow <= slower_i;
      end
    end
  end

  assign signal_o   = r_signal;
  assign strobe_o   = r_strobe;
  assign underrun_o = r_underrun;
  assign locked_o   = w_run;

endmodule
